// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between NUM_REQ requesters.
// Drives the UART new_data/din_tx handshake and aborts a phase after TIMEOUT_CYC cycles.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned TIMEOUT_CYC = 8192
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  output logic [NUM_REQ-1:0]   err,
  output logic                 busy,
  output logic                 new_data,
  output logic [7:0]           din_tx,
  input  logic                 tx,
  input  logic                 done_tx
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CW-1:0]      CNT_MAX = CW'(TIMEOUT_CYC - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_DONE, FINISH} state_t;

  state_t               r_state;
  state_t               w_next;
  logic [IW-1:0]        r_winner;
  logic [IW-1:0]        r_last;
  logic [CW-1:0]        r_cnt;
  logic                 r_done_q;
  logic [NUM_REQ-1:0]   r_ack;
  logic [NUM_REQ-1:0]   r_err;
  logic                 r_busy;
  logic                 r_new_data;
  logic [7:0]           r_din;

  logic [7:0]           w_bytes [NUM_REQ];
  logic [IW-1:0]        w_win;
  logic                 w_found;
  int unsigned          w_pos;
  logic                 w_timeout;
  logic                 w_grant;
  logic                 w_ack_set;
  logic                 w_err_set;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
    assign w_bytes[g] = req_data[8*g+7 : 8*g];
  end

  // Round-robin search starting just after the last served requester
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_pos   = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_pos = 32'(r_last) + 32'd1 + k;
      if (w_pos >= NUM_REQ) w_pos = w_pos - NUM_REQ;
      if (!w_found && req[IW'(w_pos)]) begin
        w_found = 1'b1;
        w_win   = IW'(w_pos);
      end
    end
  end

  assign w_timeout = (r_cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Qualifying events take priority over a simultaneous timeout
  always_comb begin
    w_next    = r_state;
    w_grant   = 1'b0;
    w_ack_set = 1'b0;
    w_err_set = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_next  = LOAD;
          w_grant = 1'b1;
        end
      end
      LOAD: begin
        if (!tx) begin
          w_next = WAIT_DONE;
        end else if (w_timeout) begin
          w_next    = IDLE;
          w_err_set = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (done_tx && !r_done_q) begin
          w_next    = FINISH;
          w_ack_set = 1'b1;
        end else if (w_timeout) begin
          w_next    = IDLE;
          w_err_set = 1'b1;
        end
      end
      FINISH:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_winner   <= '0;
      r_last     <= IW'(NUM_REQ - 1);
      r_cnt      <= '0;
      r_done_q   <= 1'b0;
      r_ack      <= '0;
      r_err      <= '0;
      r_busy     <= 1'b0;
      r_new_data <= 1'b0;
      r_din      <= 8'h00;
    end else begin
      r_done_q   <= done_tx;
      r_busy     <= (w_next != IDLE);
      r_new_data <= (w_next == LOAD);
      r_ack      <= w_ack_set ? (ONE_HOT0 << r_winner) : '0;
      r_err      <= w_err_set ? (ONE_HOT0 << r_winner) : '0;
      if (w_grant) begin
        r_winner <= w_win;
        r_din    <= w_bytes[w_win];
      end
      if (w_ack_set || w_err_set) r_last <= r_winner;
      // Phase counter restarts on every state change
      if (w_next != r_state) begin
        r_cnt <= '0;
      end else if (r_state == LOAD || r_state == WAIT_DONE) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign ack      = r_ack;
  assign err      = r_err;
  assign busy     = r_busy;
  assign new_data = r_new_data;
  assign din_tx   = r_din;

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of requesters sharing one UART transmitter.
REQ-002 Parameter TIMEOUT_CYC, default 8192, SHALL set the clk cycles allowed per phase (start wait, done wait) before abort.
REQ-003 clk  input  1  system clock; all logic on posedge; same clock as the UART.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 req  input  NUM_REQ  per-requester request; held high with data stable until ack or err.
REQ-006 req_data  input  8*NUM_REQ  packed bytes; requester i at bits [8i+7:8i].
REQ-007 ack  output  NUM_REQ  one-hot, 1-cycle pulse: byte of requester i fully transmitted.
REQ-008 err  output  NUM_REQ  one-hot, 1-cycle pulse: transfer of requester i aborted by timeout.
REQ-009 busy  output  1  high whenever FSM is not IDLE.
REQ-010 new_data  output  1  drives UART new_data.
REQ-011 din_tx  output  8  drives UART din_tx.
REQ-012 tx  input  1  UART serial line, observed for start bit.
REQ-013 done_tx  input  1  UART transmit-done flag.

Function
REQ-014 FSM states SHALL be IDLE, LOAD, WAIT_DONE, FINISH.
REQ-015 IDLE: if any req bit high, SHALL latch winner index and its byte into din_tx, go to LOAD next cycle; else stay.
REQ-016 Arbitration SHALL be round-robin: search starts at (last_granted+1) mod NUM_REQ; last_granted resets to NUM_REQ-1 so requester 0 wins first.
REQ-017 last_granted SHALL update on ack or err only.
REQ-018 LOAD: new_data SHALL be high; on first clk with tx==0 (start bit), SHALL deassert new_data next cycle and go to WAIT_DONE.
REQ-019 WAIT_DONE: SHALL wait for a 0->1 edge of done_tx (registered previous value); a done_tx already high on entry SHALL NOT count.
REQ-020 On that edge, SHALL go to FINISH; FINISH SHALL pulse ack[winner] for exactly one cycle and return to IDLE.
REQ-021 din_tx SHALL stay constant from IDLE exit to FINISH exit; changes to req_data meanwhile SHALL be ignored.
REQ-022 A per-phase counter SHALL clear on entry to LOAD and to WAIT_DONE and increment each cycle in those states.
REQ-023 Counter reaching TIMEOUT_CYC-1 SHALL force new_data low, pulse err[winner] one cycle, return to IDLE; ack SHALL NOT pulse.
REQ-024 Timeout and qualifying event in the same cycle: event SHALL win.
REQ-025 Requester deasserting req mid-transfer SHALL NOT abort; transfer completes and ack still pulses.
REQ-026 At most one bit of ack|err SHALL be high in any cycle; ack and err never overlap.
REQ-027 Minimum gap between back-to-back transfers: FINISH -> IDLE -> LOAD = 2 clk cycles.
REQ-028 Counter width SHALL be $clog2(TIMEOUT_CYC)+1; no wrap before timeout.

Reset
REQ-029 rst low SHALL immediately force: state IDLE, new_data 0, din_tx 8'h00, ack 0, err 0, busy 0, counter 0, last_granted NUM_REQ-1, done_tx history 0.
REQ-030 Reset mid-transfer SHALL abandon it with no ack/err; arbitration after release restarts from requester 0.
REQ-031 Outputs SHALL be valid from the first posedge after rst deasserts.

Verification
REQ-032 Single: req=4'b0100, byte2=8'hA5 -> din_tx=A5, new_data high until tx falls, UART emits A5, ack=4'b0100 one cycle.
REQ-033 Contention: req=4'b1111 held, bytes 11,22,33,44 -> ack order 0,1,2,3,0, bytes on line 11,22,33,44,11.
REQ-034 Fairness: req0 always high, req3 raised after first ack -> grant order 0,3,0,3.
REQ-035 Timeout: TIMEOUT_CYC=64, tx tied 1, req=4'b0001 -> new_data drops, err=4'b0001 at cycle 64 after LOAD entry, no ack, busy low.
REQ-036 Reset mid-byte: rst low in WAIT_DONE -> all outputs at reset values same cycle, no ack/err; req=4'b1000 after release -> requester 3 served.
REQ-037 Stale done: done_tx forced high at LOAD exit -> no ack until done_tx falls and rises again.
